mtm_alu_serializer: RTL and testbench

Transmit side of the mtm_Alu serial link. It takes a completed ALU result (32-bit C plus control byte) or an error response from the ALU core. It drives it bit-serially on sout using the same 11-bit frame format the input deserializer receives. It sits between the ALU core output register and the chip output pad.

---
 rtl/mtm_alu_pkg.sv | 19 +
 rtl/mtm_alu_frame_tx.sv | 91 +++++++++
 rtl/mtm_alu_serializer.sv | 114 +++++++++++
 tb/tb_mtm_alu_serializer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/mtm_alu_pkg.sv
// Shared definitions for the mtm_Alu serial link: the frame FSM state encoding
// and the fixed bit values of the 11-bit frame.
package mtm_alu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_TYPE  = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4
  } tx_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic TYPE_DATA = 1'b0;
  localparam logic TYPE_CMD  = 1'b1;
  localparam int   FRAME_LEN = 11;

endpackage

// File: rtl/mtm_alu_frame_tx.sv
// Shifts out one 11-bit frame {start, type, payload MSB first, stop}; a go strobe
// seen during the stop bit chains the next frame with no idle gap.
module mtm_alu_frame_tx
  import mtm_alu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              type_in,
  input  logic [DATA_W-1:0] byte_in,
  output logic              sout,
  output logic              in_stop,
  output logic              stop_next
);

  localparam int CNT_W = $clog2(DATA_W);

  tx_state_e         state_q, state_d;
  logic              sout_q, sout_d;
  logic              type_q, type_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;

  // state_q names the bit currently on sout; the next bit is prepared one cycle ahead
  always_comb begin
    state_d   = state_q;
    sout_d    = sout_q;
    type_d    = type_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      ST_IDLE, ST_STOP: begin
        sout_d  = STOP_BIT;
        state_d = ST_IDLE;
        if (go) begin
          state_d = ST_START;
          sout_d  = START_BIT;
          type_d  = type_in;
          shift_d = byte_in;
        end
      end
      ST_START: begin
        state_d = ST_TYPE;
        sout_d  = type_q;
      end
      ST_TYPE: begin
        state_d   = ST_DATA;
        sout_d    = shift_q[DATA_W-1];
        shift_d   = shift_q << 1;
        bit_cnt_d = CNT_W'(DATA_W - 1);
      end
      ST_DATA: begin
        if (bit_cnt_q == '0) begin
          state_d = ST_STOP;
          sout_d  = STOP_BIT;
        end else begin
          sout_d    = shift_q[DATA_W-1];
          shift_d   = shift_q << 1;
          bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sout_d  = STOP_BIT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sout_q    <= STOP_BIT;
      type_q    <= TYPE_DATA;
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sout_q    <= sout_d;
      type_q    <= type_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign sout      = sout_q;
  assign in_stop   = (state_q == ST_STOP);
  assign stop_next = (state_q == ST_DATA) && (bit_cnt_q == '0);

endmodule

// File: rtl/mtm_alu_serializer.sv
// Transmit side of the mtm_Alu link: sequences the DATA frames of C and the final
// CMD frame (or a lone CMD frame for errors) and owns busy/done.
module mtm_alu_serializer
  import mtm_alu_pkg::*;
#(
  parameter int N_DATA_FRAMES = 4,
  parameter int DATA_W        = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_DATA_FRAMES*DATA_W-1:0] c_in,
  input  logic [DATA_W-1:0]               ctl_in,
  input  logic                            err_in,
  input  logic                            valid_in,
  output logic                            busy,
  output logic                            done,
  output logic                            sout
);

  localparam int         C_W         = N_DATA_FRAMES * DATA_W;
  localparam int         SR_W        = C_W + DATA_W;
  localparam logic [2:0] LAST_NORMAL = 3'(N_DATA_FRAMES);

  logic [SR_W-1:0]   shreg_q, shreg_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [2:0]        frame_cnt_q, frame_cnt_d;
  logic [2:0]        last_idx;
  logic              accept;
  logic              tx_go;
  logic              tx_type;
  logic [DATA_W-1:0] tx_byte;
  logic              tx_in_stop;
  logic              tx_stop_next;

  assign accept   = valid_in && !busy_q;
  assign last_idx = err_q ? 3'd0 : LAST_NORMAL;

  // The first frame is fed straight from the inputs so its start bit lands in the
  // cycle after acceptance; later frames take the byte just below the top of shreg.
  always_comb begin
    shreg_d     = shreg_q;
    err_d       = err_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    frame_cnt_d = frame_cnt_q;
    tx_go       = 1'b0;
    tx_type     = TYPE_DATA;
    tx_byte     = shreg_q[SR_W-DATA_W-1 -: DATA_W];
    if (accept) begin
      busy_d      = 1'b1;
      err_d       = err_in;
      frame_cnt_d = 3'd0;
      shreg_d     = {c_in, ctl_in};
      tx_go       = 1'b1;
      if (err_in) begin
        tx_type = TYPE_CMD;
        tx_byte = ctl_in;
      end else begin
        tx_type = TYPE_DATA;
        tx_byte = c_in[C_W-1 -: DATA_W];
      end
    end else if (busy_q) begin
      if (tx_stop_next && (frame_cnt_q == last_idx)) begin
        done_d = 1'b1;
      end
      if (tx_in_stop) begin
        if (frame_cnt_q == last_idx) begin
          busy_d      = 1'b0;
          frame_cnt_d = 3'd0;
        end else begin
          tx_go       = 1'b1;
          frame_cnt_d = frame_cnt_q + 3'd1;
          tx_type     = ((frame_cnt_q + 3'd1) == last_idx) ? TYPE_CMD : TYPE_DATA;
          shreg_d     = shreg_q << DATA_W;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q     <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      frame_cnt_q <= 3'd0;
    end else begin
      shreg_q     <= shreg_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  mtm_alu_frame_tx #(
    .DATA_W (DATA_W)
  ) u_frame_tx (
    .clk       (clk),
    .rst       (rst),
    .go        (tx_go),
    .type_in   (tx_type),
    .byte_in   (tx_byte),
    .sout      (sout),
    .in_stop   (tx_in_stop),
    .stop_next (tx_stop_next)
  );

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_mtm_alu_serializer.sv
// Bench for mtm_alu_serializer: directed and random responses compared bit by bit
// against a frame-level model of the expected serial waveform.
module tb_mtm_alu_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] c_in;
  logic [7:0]  ctl_in;
  logic        err_in;
  logic        valid_in;
  logic        busy;
  logic        done;
  logic        sout;

  int n_tests = 0;
  int n_fail  = 0;
  int resp_id = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  mtm_alu_serializer #(
    .N_DATA_FRAMES (4),
    .DATA_W        (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .c_in     (c_in),
    .ctl_in   (ctl_in),
    .err_in   (err_in),
    .valid_in (valid_in),
    .busy     (busy),
    .done     (done),
    .sout     (sout)
  );

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed sout/busy/done=%b expected %b", tag, obs, exp);
    end
  endtask

  // Expected waveform: list the payload bytes, then wrap each in start/type/stop.
  task automatic build(input logic [31:0] c, input logic [7:0] ctl, input logic e);
    logic [7:0] bytes[$];
    exp_q.delete();
    if (!e) for (int k = 3; k >= 0; k--) bytes.push_back(c[8*k +: 8]);
    bytes.push_back(ctl);
    foreach (bytes[j]) begin
      exp_q.push_back(1'b0);
      exp_q.push_back(j == bytes.size() - 1);
      for (int b = 7; b >= 0; b--) exp_q.push_back(bytes[j][b]);
      exp_q.push_back(1'b1);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_resp(input logic [31:0] c, input logic [7:0] ctl, input logic e,
                          input int inject_at, input int abort_at, input bit noise,
                          input bit chain, input logic [31:0] nc, input logic [7:0] nctl,
                          input logic ne);
    bit q[$];
    int len;
    logic [2:0] exp;
    resp_id++;
    build(c, ctl, e);
    q = exp_q;
    len = q.size();
    c_in = c; ctl_in = ctl; err_in = e; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    c_in = $urandom; ctl_in = 8'($urandom); err_in = 1'($urandom);
    for (int i = 1; i <= len; i++) begin
      exp = {q[i-1], 1'b1, (i == len)};
      chk($sformatf("r%0d_cyc%0d", resp_id, i), {sout, busy, done}, exp);
      valid_in = 1'b0;
      if (i == abort_at) begin
        #2 rst = 1'b1;
        #1 chk($sformatf("r%0d_async_rst", resp_id), {sout, busy, done}, 3'b100);
        tick();
        chk($sformatf("r%0d_in_rst", resp_id), {sout, busy, done}, 3'b100);
        #3 rst = 1'b0;
        tick();
        chk($sformatf("r%0d_after_rst", resp_id), {sout, busy, done}, 3'b100);
        return;
      end
      if (noise) begin
        valid_in = 1'($urandom);
        c_in = $urandom; ctl_in = 8'($urandom); err_in = 1'($urandom);
      end
      if (i == inject_at) begin
        valid_in = 1'b1; c_in = 32'hDEADBEEF; err_in = 1'b0;
      end
      if (i == len) begin
        valid_in = 1'b0;
        if (chain) begin
          valid_in = 1'b1; c_in = nc; ctl_in = nctl; err_in = ne;
        end
      end
      tick();
    end
    chk($sformatf("r%0d_idle_after", resp_id), {sout, busy, done}, 3'b100);
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; c_in = '0; ctl_in = '0; err_in = 1'b0;
    #2 chk("reset_state", {sout, busy, done}, 3'b100);
    tick(); tick();
    #2 rst = 1'b0;
    tick();

    // Idle after reset
    for (int i = 0; i < 100; i++) begin
      chk($sformatf("idle_%0d", i), {sout, busy, done}, 3'b100);
      tick();
    end

    // Normal and error responses
    run_resp(32'h12345678, 8'h0B, 1'b0, 0, 0, 1'b0, 1'b0, '0, '0, 1'b0);
    tick();
    run_resp(32'hFFFFFFFF, 8'hC9, 1'b1, 0, 0, 1'b0, 1'b0, '0, '0, 1'b0);
    tick();

    // Valid while busy must be ignored, and no second response may follow
    run_resp(32'h12345678, 8'h0B, 1'b0, 20, 0, 1'b0, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 60; i++) begin
      chk($sformatf("no_second_%0d", i), {sout, busy, done}, 3'b100);
      tick();
    end

    // Back-to-back: valid held from the last stop bit, accepted on first idle edge
    run_resp(32'hA5C3_0F96, 8'h3C, 1'b0, 0, 0, 1'b0, 1'b1, 32'h0102_0304, 8'h55, 1'b0);
    run_resp(32'h0102_0304, 8'h55, 1'b0, 0, 0, 1'b0, 1'b1, 32'h0, 8'hE7, 1'b1);
    run_resp(32'h0,         8'hE7, 1'b1, 0, 0, 1'b0, 1'b0, '0, '0, 1'b0);
    tick();

    // Reset mid-frame, then a clean error response
    run_resp(32'h12345678, 8'h0B, 1'b0, 0, 30, 1'b0, 1'b0, '0, '0, 1'b0);
    tick();
    run_resp(32'h0, 8'h80, 1'b1, 0, 0, 1'b0, 1'b0, '0, '0, 1'b0);

    // Random responses with input churn during busy and random idle gaps
    for (int n = 0; n < 25; n++) begin
      logic [31:0] rc;
      logic [7:0]  rctl;
      logic        re;
      int          gap;
      rc = $urandom; rctl = 8'($urandom); re = ($urandom_range(0, 3) == 0);
      run_resp(rc, rctl, re, 0, 0, 1'b1, 1'b0, '0, '0, 1'b0);
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        tick();
        chk($sformatf("gap%0d_%0d", n, g), {sout, busy, done}, 3'b100);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
